// File: rtl/fano_sync_ctrl_if.sv
// -----------------------------------------------------------------------------
// fano_sync_ctrl_if
// Bundle of configuration, decoder status and control signals exchanged
// between a host (master) and the Fano decoder sync controller (slave).
//   i_enable      run acquisition
//   i_num_hyp     number of phase/mapping hypotheses (0 behaves as 1)
//   i_settle      cycles to wait after an LLR reset before observing
//   i_dwell       observation window length in decoder input symbols
//   i_lose_cnt    consecutive sync-less windows that declare loss
//   i_sym_vld     one decoder input symbol accepted this cycle
//   i_is_sync     decoder sync indicator (level)
//   o_llr_reset   decoder LLR/path-metric reset
//   o_shift_phase one-cycle strobe: hypothesis changed
//   o_hyp         current hypothesis index
//   o_locked      decoder locked on current hypothesis
//   o_state       FSM state code
//   o_sweeps      completed full hypothesis sweeps (saturating)
// -----------------------------------------------------------------------------
interface fano_sync_ctrl_if #(
    parameter int HYP_W = 3,
    parameter int WIN_W = 24
);
    logic             i_enable;
    logic [HYP_W-1:0] i_num_hyp;
    logic [15:0]      i_settle;
    logic [WIN_W-1:0] i_dwell;
    logic [7:0]       i_lose_cnt;
    logic             i_sym_vld;
    logic             i_is_sync;
    logic             o_llr_reset;
    logic             o_shift_phase;
    logic [HYP_W-1:0] o_hyp;
    logic             o_locked;
    logic [2:0]       o_state;
    logic [7:0]       o_sweeps;

    modport master (
        output i_enable, i_num_hyp, i_settle, i_dwell, i_lose_cnt,
               i_sym_vld, i_is_sync,
        input  o_llr_reset, o_shift_phase, o_hyp, o_locked, o_state, o_sweeps
    );

    modport slave (
        input  i_enable, i_num_hyp, i_settle, i_dwell, i_lose_cnt,
               i_sym_vld, i_is_sync,
        output o_llr_reset, o_shift_phase, o_hyp, o_locked, o_state, o_sweeps
    );
endinterface

// File: rtl/fano_sync_ctrl.sv
// -----------------------------------------------------------------------------
// fano_sync_ctrl
// Acquisition controller for a Fano decoder: steps through phase/mapping
// hypotheses, resetting the decoder metrics and watching its sync indicator
// for a dwell window on each, then supervises lock and re-acquires on loss.
// Ports:
//   clk     system clock, rising edge
//   nRESET  synchronous active-low reset
//   bus     fano_sync_ctrl_if.slave (configuration, decoder status, outputs)
// All outputs are flops. Each output flop is loaded from the next state, so
// o_llr_reset / o_shift_phase / o_locked are exactly coincident with the
// RST / ADVANCE / LOCKED state codes. o_hyp takes its new value on entry to
// ADVANCE, i.e. together with the o_shift_phase strobe.
// -----------------------------------------------------------------------------
module fano_sync_ctrl #(
    parameter int HYP_W = 3,
    parameter int WIN_W = 24
) (
    input  logic             clk,
    input  logic             nRESET,
    fano_sync_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RST     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_LOCKED  = 3'd5
    } state_t;

    state_t           state_q,       state_d;
    logic [15:0]      cyc_cnt_q,     cyc_cnt_d;
    logic [WIN_W-1:0] sym_cnt_q,     sym_cnt_d;
    logic [7:0]       miss_cnt_q,    miss_cnt_d;
    logic             seen_sync_q,   seen_sync_d;
    logic [HYP_W-1:0] num_hyp_q,     num_hyp_d;
    logic [15:0]      settle_q,      settle_d;
    logic [WIN_W-1:0] dwell_q,       dwell_d;
    logic [7:0]       lose_q,        lose_d;
    logic [HYP_W-1:0] hyp_q,         hyp_d;
    logic [7:0]       sweeps_q,      sweeps_d;
    logic             llr_reset_q,   llr_reset_d;
    logic             shift_phase_q, shift_phase_d;
    logic             locked_q,      locked_d;

    // Zero-valued configuration behaves as one; "last" values are the
    // terminal counts of up-counters cleared on state entry.
    logic [HYP_W-1:0] num_hyp_eff;
    logic [15:0]      settle_last;
    logic [WIN_W-1:0] dwell_last;
    logic [7:0]       lose_eff;
    logic             win_end;
    logic             hyp_wrap;

    assign num_hyp_eff = (num_hyp_q == {HYP_W{1'b0}}) ? {{(HYP_W-1){1'b0}}, 1'b1} : num_hyp_q;
    assign settle_last = (settle_q == 16'd0) ? 16'd0 : settle_q - 16'd1;
    assign dwell_last  = (dwell_q == {WIN_W{1'b0}}) ? {WIN_W{1'b0}} : dwell_q - {{(WIN_W-1){1'b0}}, 1'b1};
    assign lose_eff    = (lose_q == 8'd0) ? 8'd1 : lose_q;
    assign win_end     = bus.i_sym_vld && (sym_cnt_q == dwell_last);
    assign hyp_wrap    = (({1'b0, hyp_q} + {{HYP_W{1'b0}}, 1'b1}) == {1'b0, num_hyp_eff});

    // Next-state, counter, configuration and output computation.
    always_comb begin
        state_d     = state_q;
        cyc_cnt_d   = cyc_cnt_q;
        sym_cnt_d   = sym_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        seen_sync_d = seen_sync_q;
        num_hyp_d   = num_hyp_q;
        settle_d    = settle_q;
        dwell_d     = dwell_q;
        lose_d      = lose_q;
        hyp_d       = hyp_q;
        sweeps_d    = sweeps_q;

        if (!bus.i_enable) begin
            // Disable wins over every other transition, including an
            // in-progress LLR reset burst.
            state_d     = ST_IDLE;
            cyc_cnt_d   = 16'd0;
            sym_cnt_d   = {WIN_W{1'b0}};
            miss_cnt_d  = 8'd0;
            seen_sync_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_RST;
                    cyc_cnt_d = 16'd0;
                    num_hyp_d = bus.i_num_hyp;
                    settle_d  = bus.i_settle;
                    dwell_d   = bus.i_dwell;
                    lose_d    = bus.i_lose_cnt;
                end
                ST_RST: begin
                    // Four-cycle LLR reset burst.
                    if (cyc_cnt_q == 16'd3) begin
                        state_d   = ST_SETTLE;
                        cyc_cnt_d = 16'd0;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 16'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cyc_cnt_q == settle_last) begin
                        state_d   = ST_SEARCH;
                        sym_cnt_d = {WIN_W{1'b0}};
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 16'd1;
                    end
                end
                ST_SEARCH: begin
                    // Sync takes priority over a window expiring on the same cycle.
                    if (bus.i_is_sync) begin
                        state_d     = ST_LOCKED;
                        sym_cnt_d   = {WIN_W{1'b0}};
                        miss_cnt_d  = 8'd0;
                        seen_sync_d = 1'b0;
                    end else if (win_end) begin
                        state_d   = ST_ADVANCE;
                        sym_cnt_d = {WIN_W{1'b0}};
                    end else if (bus.i_sym_vld) begin
                        sym_cnt_d = sym_cnt_q + {{(WIN_W-1){1'b0}}, 1'b1};
                    end else begin
                        sym_cnt_d = sym_cnt_q;
                    end
                end
                ST_ADVANCE: begin
                    state_d   = ST_RST;
                    cyc_cnt_d = 16'd0;
                end
                ST_LOCKED: begin
                    if (win_end) begin
                        sym_cnt_d   = {WIN_W{1'b0}};
                        seen_sync_d = 1'b0;
                        // A sync on the window's last symbol still counts for it.
                        if (seen_sync_q || bus.i_is_sync) begin
                            miss_cnt_d = 8'd0;
                        end else if ((miss_cnt_q + 8'd1) == lose_eff) begin
                            state_d    = ST_RST;
                            cyc_cnt_d  = 16'd0;
                            miss_cnt_d = 8'd0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 8'd1;
                        end
                    end else begin
                        sym_cnt_d   = bus.i_sym_vld ? (sym_cnt_q + {{(WIN_W-1){1'b0}}, 1'b1}) : sym_cnt_q;
                        seen_sync_d = seen_sync_q | bus.i_is_sync;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Hypothesis and sweep bookkeeping follow the next state.
        if (state_d == ST_IDLE) begin
            hyp_d    = {HYP_W{1'b0}};
            sweeps_d = 8'd0;
        end else if (state_d == ST_ADVANCE) begin
            if (hyp_wrap) begin
                hyp_d    = {HYP_W{1'b0}};
                sweeps_d = (sweeps_q == 8'hFF) ? sweeps_q : sweeps_q + 8'd1;
            end else begin
                hyp_d    = hyp_q + {{(HYP_W-1){1'b0}}, 1'b1};
                sweeps_d = sweeps_q;
            end
        end else begin
            hyp_d    = hyp_q;
            sweeps_d = sweeps_q;
        end

        llr_reset_d   = (state_d == ST_RST);
        shift_phase_d = (state_d == ST_ADVANCE);
        locked_d      = (state_d == ST_LOCKED);
    end

    // State, counter, configuration and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q       <= ST_IDLE;
            cyc_cnt_q     <= 16'd0;
            sym_cnt_q     <= {WIN_W{1'b0}};
            miss_cnt_q    <= 8'd0;
            seen_sync_q   <= 1'b0;
            num_hyp_q     <= {HYP_W{1'b0}};
            settle_q      <= 16'd0;
            dwell_q       <= {WIN_W{1'b0}};
            lose_q        <= 8'd0;
            hyp_q         <= {HYP_W{1'b0}};
            sweeps_q      <= 8'd0;
            llr_reset_q   <= 1'b0;
            shift_phase_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_cnt_q     <= cyc_cnt_d;
            sym_cnt_q     <= sym_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            seen_sync_q   <= seen_sync_d;
            num_hyp_q     <= num_hyp_d;
            settle_q      <= settle_d;
            dwell_q       <= dwell_d;
            lose_q        <= lose_d;
            hyp_q         <= hyp_d;
            sweeps_q      <= sweeps_d;
            llr_reset_q   <= llr_reset_d;
            shift_phase_q <= shift_phase_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.o_llr_reset   = llr_reset_q;
    assign bus.o_shift_phase = shift_phase_q;
    assign bus.o_hyp         = hyp_q;
    assign bus.o_locked      = locked_q;
    assign bus.o_state       = state_q;
    assign bus.o_sweeps      = sweeps_q;
endmodule

// File: tb/tb_fano_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fano_sync_ctrl
// Directed scenarios with hand-computed expectations, plus a cycle-level
// behavioural model (countdown timers, modulo hypothesis stepping) that is
// compared against every DUT output on every cycle.
// -----------------------------------------------------------------------------
module tb_fano_sync_ctrl;
    localparam int HYP_W = 3;
    localparam int WIN_W = 24;

    logic clk = 1'b0;
    logic nRESET;
    bit   chk_on = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   shift_hist[$];

    fano_sync_ctrl_if #(.HYP_W(HYP_W), .WIN_W(WIN_W)) bus ();

    fano_sync_ctrl #(.HYP_W(HYP_W), .WIN_W(WIN_W)) dut (
        .clk    (clk),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state = 0, m_left = 0, m_hyp = 0, m_sweeps = 0, m_miss = 0;
    bit m_seen = 1'b0;
    int c_nh = 1, c_st = 1, c_dw = 1, c_lc = 1;

    always @(posedge clk) begin
        if (!nRESET) begin
            m_state = 0; m_left = 0; m_hyp = 0; m_sweeps = 0; m_miss = 0; m_seen = 1'b0;
        end else if (!bus.i_enable) begin
            m_state = 0; m_hyp = 0; m_sweeps = 0;
        end else begin
            case (m_state)
                0: begin
                    c_nh = (bus.i_num_hyp == 0)  ? 1 : int'(bus.i_num_hyp);
                    c_st = (bus.i_settle == 0)   ? 1 : int'(bus.i_settle);
                    c_dw = (bus.i_dwell == 0)    ? 1 : int'(bus.i_dwell);
                    c_lc = (bus.i_lose_cnt == 0) ? 1 : int'(bus.i_lose_cnt);
                    m_state = 1; m_left = 4;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_state = 2; m_left = c_st; end
                end
                2: begin
                    m_left--;
                    if (m_left == 0) begin m_state = 3; m_left = c_dw; end
                end
                3: begin
                    if (bus.i_is_sync) begin
                        m_state = 5; m_left = c_dw; m_miss = 0; m_seen = 1'b0;
                    end else if (bus.i_sym_vld) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_state = 4;
                            m_hyp = (m_hyp + 1) % c_nh;
                            if (m_hyp == 0 && m_sweeps < 255) m_sweeps++;
                        end
                    end
                end
                4: begin m_state = 1; m_left = 4; end
                5: begin
                    if (bus.i_is_sync) m_seen = 1'b1;
                    if (bus.i_sym_vld) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_left = c_dw;
                            m_miss = m_seen ? 0 : m_miss + 1;
                            m_seen = 1'b0;
                            if (m_miss == c_lc) begin m_state = 1; m_left = 4; m_miss = 0; end
                        end
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_state",  int'(bus.o_state),       m_state);
            chk("model_llr",    int'(bus.o_llr_reset),   (m_state == 1) ? 1 : 0);
            chk("model_shift",  int'(bus.o_shift_phase), (m_state == 4) ? 1 : 0);
            chk("model_locked", int'(bus.o_locked),      (m_state == 5) ? 1 : 0);
            chk("model_hyp",    int'(bus.o_hyp),         m_hyp);
            chk("model_sweeps", int'(bus.o_sweeps),      m_sweeps);
        end
    end

    // Records the hypothesis shown with each shift strobe.
    always @(negedge clk) begin
        if (bus.o_shift_phase === 1'b1) shift_hist.push_back(int'(bus.o_hyp));
    end

    // Leaves the current (IDLE) cycle as cycle N with enable asserted.
    task automatic restart(input int nh, input int st, input int dw, input int lc);
        bus.i_enable = 1'b0;
        @(negedge clk);
        bus.i_num_hyp  = HYP_W'(nh);
        bus.i_settle   = 16'(st);
        bus.i_dwell    = WIN_W'(dw);
        bus.i_lose_cnt = 8'(lc);
        bus.i_sym_vld  = 1'b1;
        bus.i_is_sync  = 1'b0;
        bus.i_enable   = 1'b1;
        shift_hist.delete();
    endtask

    initial begin
        nRESET = 1'b0;
        bus.i_enable = 1'b0; bus.i_num_hyp = '0; bus.i_settle = '0; bus.i_dwell = '0;
        bus.i_lose_cnt = '0; bus.i_sym_vld = 1'b0; bus.i_is_sync = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_state",  int'(bus.o_state),     0);
        chk("rst_llr",    int'(bus.o_llr_reset), 0);
        chk("rst_hyp",    int'(bus.o_hyp),       0);
        chk("rst_sweeps", int'(bus.o_sweeps),    0);
        nRESET = 1'b1;

        // Acquire, lock, miss counting with a mid-run sync, loss, enable abort.
        restart(4, 10, 8, 3);
        for (int j = 1; j <= 63; j++) begin
            @(negedge clk);
            if (j <= 4) begin
                chk("a_rst_state", int'(bus.o_state), 1);
                chk("a_llr_hi",    int'(bus.o_llr_reset), 1);
            end else if (j <= 14) begin
                chk("a_settle", int'(bus.o_state), 2);
                chk("a_llr_lo", int'(bus.o_llr_reset), 0);
            end else if (j <= 20) begin
                chk("a_search", int'(bus.o_state), 3);
            end else if (j == 21) begin
                chk("a_locked", int'(bus.o_locked), 1);
                chk("a_hyp0",   int'(bus.o_hyp), 0);
            end else if (j == 45 || j == 60) begin
                chk("a_hold_lock", int'(bus.o_locked), 1);
            end else if (j == 61) begin
                chk("a_loss_state",  int'(bus.o_state), 1);
                chk("a_loss_locked", int'(bus.o_locked), 0);
                chk("a_loss_hyp",    int'(bus.o_hyp), 0);
            end else if (j == 62) begin
                chk("a_rst2_llr", int'(bus.o_llr_reset), 1);
            end else if (j == 63) begin
                chk("a_abort_state", int'(bus.o_state), 0);
                chk("a_abort_llr",   int'(bus.o_llr_reset), 0);
                chk("a_abort_hyp",   int'(bus.o_hyp), 0);
            end
            if (j == 20) bus.i_is_sync = 1'b1;
            if (j == 21) bus.i_is_sync = 1'b0;
            if (j == 32) bus.i_is_sync = 1'b1;
            if (j == 33) bus.i_is_sync = 1'b0;
            if (j == 62) bus.i_enable  = 1'b0;
        end

        // Full sweep over four hypotheses without sync.
        restart(4, 2, 8, 3);
        for (int j = 1; j <= 62; j++) @(negedge clk);
        chk("b_shift_count", shift_hist.size(), 4);
        chk("b_hyp_seq0", shift_hist[0], 1);
        chk("b_hyp_seq1", shift_hist[1], 2);
        chk("b_hyp_seq2", shift_hist[2], 3);
        chk("b_hyp_seq3", shift_hist[3], 0);
        chk("b_sweeps",   int'(bus.o_sweeps), 1);

        // Sync coincident with the 8th symbol; settle 0 behaves as 1.
        restart(2, 0, 8, 3);
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (j == 5) chk("c_settle1", int'(bus.o_state), 2);
            if (j == 6) chk("c_search",  int'(bus.o_state), 3);
            if (j == 13) bus.i_is_sync = 1'b1;
        end
        chk("c_locked_state", int'(bus.o_state), 5);
        chk("c_no_shift",     shift_hist.size(), 0);
        chk("c_hyp",          int'(bus.o_hyp), 0);

        // Sweep counter saturation with one hypothesis and a one-symbol dwell.
        restart(0, 0, 0, 1);
        for (int j = 1; j <= 1900; j++) begin
            @(negedge clk);
            if (j == 7) begin
                chk("e_first_adv",    int'(bus.o_state), 4);
                chk("e_first_sweeps", int'(bus.o_sweeps), 1);
            end
        end
        chk("e_sat_sweeps", int'(bus.o_sweeps), 255);
        chk("e_sat_hyp",    int'(bus.o_hyp), 0);

        // Lock on the second hypothesis, then a reset pulse while locked.
        restart(3, 0, 2, 3);
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            if (j == 8) chk("f_adv_hyp", int'(bus.o_hyp), 1);
            if (j == 15) begin
                chk("f_locked",     int'(bus.o_locked), 1);
                chk("f_locked_hyp", int'(bus.o_hyp), 1);
            end
            if (j == 17) begin
                chk("f_nrst_state",  int'(bus.o_state), 0);
                chk("f_nrst_llr",    int'(bus.o_llr_reset), 0);
                chk("f_nrst_hyp",    int'(bus.o_hyp), 0);
                chk("f_nrst_sweeps", int'(bus.o_sweeps), 0);
                chk("f_nrst_locked", int'(bus.o_locked), 0);
                chk("f_nrst_shift",  int'(bus.o_shift_phase), 0);
            end
            if (j == 18) chk("f_rerun_state", int'(bus.o_state), 1);
            if (j == 14) bus.i_is_sync = 1'b1;
            if (j == 16) nRESET = 1'b0;
            if (j == 17) nRESET = 1'b1;
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fano_sync_ctrl.md
FANO_SYNC_CTRL -- requirements
Module: fano_sync_ctrl

Interface
REQ-001 SHALL have parameter HYP_W, default 3, width of hypothesis index.
REQ-002 SHALL have parameter WIN_W, default 24, width of dwell/window counters.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port nRESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_enable  input  1  run acquisition; low forces IDLE.
REQ-006 SHALL have port i_num_hyp  input  HYP_W  number of phase/mapping hypotheses; 0 treated as 1.
REQ-007 SHALL have port i_settle  input  16  clk cycles to wait after LLR reset before observing.
REQ-008 SHALL have port i_dwell  input  WIN_W  observation window length in decoder input symbols; 0 treated as 1.
REQ-009 SHALL have port i_lose_cnt  input  8  consecutive sync-less windows that declare loss; 0 treated as 1.
REQ-010 SHALL have port i_sym_vld  input  1  one decoder input symbol accepted this cycle.
REQ-011 SHALL have port i_is_sync  input  1  decoder sync indicator, level.
REQ-012 SHALL have port o_llr_reset  output  1  decoder LLR/path-metric reset.
REQ-013 SHALL have port o_shift_phase  output  1  one-cycle strobe: hypothesis changed.
REQ-014 SHALL have port o_hyp  output  HYP_W  current hypothesis index to the rotator.
REQ-015 SHALL have port o_locked  output  1  decoder locked on current hypothesis.
REQ-016 SHALL have port o_state  output  3  FSM state code.
REQ-017 SHALL have port o_sweeps  output  8  completed full hypothesis sweeps, saturating at 255.

Function
REQ-018 FSM states/codes SHALL be IDLE=0, RST=1, SETTLE=2, SEARCH=3, ADVANCE=4, LOCKED=5; o_state registered, equal to current state.
REQ-019 i_num_hyp, i_settle, i_dwell, i_lose_cnt SHALL be latched on IDLE->RST and held constant until next IDLE.
REQ-020 IDLE: o_hyp=0, o_sweeps=0, all strobes low; i_enable high -> RST next cycle.
REQ-021 RST: o_llr_reset high exactly 4 consecutive cycles (registered, coincident with state RST), then SETTLE.
REQ-022 SETTLE: wait latched i_settle cycles (0 -> one cycle) then SEARCH; i_sym_vld and i_is_sync ignored.
REQ-023 SEARCH: symbol counter cleared on entry, increments per i_sym_vld; i_is_sync high -> LOCKED next cycle.
REQ-024 SEARCH: counter reaching latched i_dwell without i_is_sync -> ADVANCE; simultaneous sync and expiry SHALL go to LOCKED.
REQ-025 ADVANCE: single cycle, o_shift_phase high, o_hyp <= o_hyp+1, wrapping to 0 when o_hyp+1 == num_hyp; -> RST.
REQ-026 Wrap in ADVANCE SHALL increment o_sweeps, saturating at 255; num_hyp=1 wraps every ADVANCE.
REQ-027 LOCKED: o_locked high for every cycle in LOCKED and only then; window counter counts i_sym_vld modulo i_dwell.
REQ-028 LOCKED: any i_is_sync in a window clears the miss counter at window end; window end without sync increments it.
REQ-029 LOCKED: miss counter reaching latched i_lose_cnt -> RST with o_hyp unchanged (re-acquire same hypothesis first), o_locked low from that cycle.
REQ-030 i_enable low in any state SHALL force IDLE next cycle, overriding all other transitions, aborting an in-progress o_llr_reset burst.
REQ-031 Counters SHALL not overflow: dwell/window counters compare with ==, reset on state entry.

Reset
REQ-032 nRESET low at a rising edge SHALL put FSM in IDLE, clear all counters and latched config, drive o_llr_reset=0, o_shift_phase=0, o_hyp=0, o_locked=0, o_state=0, o_sweeps=0.
REQ-033 Reset mid-operation (any state) SHALL take effect in one cycle with identical values; no strobe emitted after the reset edge.

Verification
REQ-034 Enable at cycle N, i_settle=10, i_dwell=8, i_is_sync=1 from N+20 -> o_llr_reset high N+1..N+4, SETTLE N+5..N+14, o_locked high by N+21, o_hyp=0.
REQ-035 num_hyp=4, i_dwell=8, i_sym_vld every cycle, i_is_sync never -> o_hyp sequence 1,2,3,0 with one o_shift_phase each, o_sweeps=1 after fourth ADVANCE.
REQ-036 Locked, i_lose_cnt=3, i_is_sync dropped -> o_locked falls exactly at end of third empty window, state RST, o_hyp unchanged; single sync pulse in window 2 restarts miss count.
REQ-037 SEARCH with i_is_sync asserted on the same cycle the 8th symbol arrives -> LOCKED, no o_shift_phase.
REQ-038 i_enable dropped during RST cycle 2, and separately nRESET pulsed in LOCKED -> next cycle IDLE, o_llr_reset=0, o_hyp=0, o_sweeps=0.
REQ-039 o_sweeps driven past 255 sweeps with num_hyp=1, i_dwell=1 -> holds 255.
